// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB register with load alignment, stall/flush, retire count; HI/LO commit when WB_HILO_EN is defined.
// Latency 1 cycle; stall_mem&stall_wb holds the stage, stall_mem alone or flush loads a bubble.
module wb_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_mem,
  input  logic              stall_wb,
  input  logic              flush,
  input  logic              mem_valid,
  input  logic              mem_wreg,
  input  logic [ADDR_W-1:0] mem_waddr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [2:0]        mem_load_op,
  input  logic [1:0]        mem_byte_off,
  output logic              wb_we,
  output logic [ADDR_W-1:0] wb_waddr,
  output logic [DATA_W-1:0] wb_wdata,
  output logic              wb_valid,
  output logic              wb_misalign,
  output logic [CNT_W-1:0]  wb_retired
`ifdef WB_HILO_EN
  ,
  input  logic              mem_whilo,
  input  logic [DATA_W-1:0] mem_hi,
  input  logic [DATA_W-1:0] mem_lo,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
`endif
);

  localparam logic [2:0] LD_LB  = 3'd1;
  localparam logic [2:0] LD_LBU = 3'd2;
  localparam logic [2:0] LD_LH  = 3'd3;
  localparam logic [2:0] LD_LHU = 3'd4;
  localparam logic [2:0] LD_LW  = 3'd5;

  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic              ld_misalign;
  logic [DATA_W-1:0] ld_data;
  logic              bubble;
  logic              hold;

  // Big-endian lane select, resolved before the register so wb_* stay pure flops.
  always_comb begin
    ld_byte     = mem_wdata[7:0];
    ld_half     = mem_byte_off[1] ? mem_wdata[15:0] : mem_wdata[31:16];
    ld_misalign = 1'b0;
    ld_data     = mem_wdata;
    case (mem_byte_off)
      2'd0:    ld_byte = mem_wdata[31:24];
      2'd1:    ld_byte = mem_wdata[23:16];
      2'd2:    ld_byte = mem_wdata[15:8];
      default: ld_byte = mem_wdata[7:0];
    endcase
    case (mem_load_op)
      LD_LB:   ld_data = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
      LD_LBU:  ld_data = {{(DATA_W-8){1'b0}}, ld_byte};
      LD_LH: begin
        ld_misalign = mem_byte_off[0];
        ld_data     = {{(DATA_W-16){ld_half[15]}}, ld_half};
      end
      LD_LHU: begin
        ld_misalign = mem_byte_off[0];
        ld_data     = {{(DATA_W-16){1'b0}}, ld_half};
      end
      LD_LW:   ld_misalign = (mem_byte_off != 2'd0);
      default: ld_data = mem_wdata;
    endcase
    if (ld_misalign) ld_data = '0;
  end

  // flush wins over a hold, so it is folded into the bubble term checked first.
  assign bubble = flush | (stall_mem & ~stall_wb);
  assign hold   = stall_mem & stall_wb;

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_we       <= 1'b0;
      wb_waddr    <= '0;
      wb_wdata    <= '0;
      wb_valid    <= 1'b0;
      wb_misalign <= 1'b0;
      wb_retired  <= '0;
    end else if (bubble) begin
      wb_we       <= 1'b0;
      wb_waddr    <= '0;
      wb_wdata    <= '0;
      wb_valid    <= 1'b0;
      wb_misalign <= 1'b0;
    end else if (!hold) begin
      wb_we       <= mem_valid & mem_wreg & (mem_waddr != '0) & ~ld_misalign;
      wb_waddr    <= mem_waddr;
      wb_wdata    <= ld_data;
      wb_valid    <= mem_valid;
      wb_misalign <= mem_valid & ld_misalign;
      if (mem_valid) wb_retired <= wb_retired + CNT_W'(1);
    end
  end

`ifdef WB_HILO_EN
  logic              whilo_q;
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;

  // Commit reads the held pair, so hi_o/lo_o trail WB capture by one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      whilo_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      hi_o    <= '0;
      lo_o    <= '0;
    end else begin
      if (whilo_q && wb_valid) begin
        hi_o <= hi_q;
        lo_o <= lo_q;
      end
      if (bubble) begin
        whilo_q <= 1'b0;
        hi_q    <= '0;
        lo_q    <= '0;
      end else if (!hold) begin
        whilo_q <= mem_whilo;
        hi_q    <= mem_hi;
        lo_q    <= mem_lo;
      end
    end
  end
`endif

endmodule
